// File: rtl/el2_ifu_iccm_repair_cam.sv
// ICCM repair CAM: up to NUM_RED corrected words replace RAM read data on matching addresses.
// True-LRU replacement via a per-entry age permutation (0 = most recently used).
module el2_ifu_iccm_repair_cam #(
  parameter int unsigned NUM_RED = 4,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 39,
  localparam int unsigned IdxW   = $clog2(NUM_RED),
  localparam int unsigned OccW   = IdxW + 1
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr_lo,
  input  logic [ADDR_W-1:0]   rd_addr_hi,
  input  logic [DATA_W-1:0]   ram_dout_lo,
  input  logic [DATA_W-1:0]   ram_dout_hi,
  output logic [DATA_W-1:0]   rd_data_lo,
  output logic [DATA_W-1:0]   rd_data_hi,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                wr_dw,
  input  logic [2*DATA_W-1:0] wr_data,
  input  logic                corr_en,
  input  logic [ADDR_W-1:0]   corr_addr,
  input  logic [DATA_W-1:0]   corr_data,
  input  logic                lock,
  input  logic                flush,
  output logic [OccW-1:0]     occupancy,
  output logic                full,
  output logic                evict_pulse,
  output logic                drop_pulse
);

  logic [NUM_RED-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]  addr_q [NUM_RED];
  logic [ADDR_W-1:0]  addr_d [NUM_RED];
  logic [DATA_W-1:0]  data_q [NUM_RED];
  logic [DATA_W-1:0]  data_d [NUM_RED];
  logic [IdxW-1:0]    age_q  [NUM_RED];
  logic [IdxW-1:0]    age_d  [NUM_RED];
  logic [NUM_RED-1:0] hit_lo_q, hit_lo_d, hit_hi_q, hit_hi_d;
  logic               evict_q, evict_d, drop_q, drop_d;

  logic [NUM_RED-1:0] lo_match, hi_match, corr_match, wr_lo_match, wr_hi_match;
  logic [ADDR_W-1:0]  wr_addr_nxt;
  logic [IdxW-1:0]    lo_idx, hi_idx, corr_idx, free_idx, lru_idx, alloc_idx, touch_idx;
  logic               any_free, touch_en;

  assign wr_addr_nxt = wr_addr + ADDR_W'(1);
  assign any_free    = ~&valid_q;

  // Descending scan so the lowest-index free entry wins.
  always_comb begin
    lo_match    = '0;
    hi_match    = '0;
    corr_match  = '0;
    wr_lo_match = '0;
    wr_hi_match = '0;
    lo_idx      = '0;
    hi_idx      = '0;
    corr_idx    = '0;
    free_idx    = '0;
    lru_idx     = '0;
    for (int i = NUM_RED - 1; i >= 0; i--) begin
      lo_match[i]    = valid_q[i] && (addr_q[i] == rd_addr_lo);
      hi_match[i]    = valid_q[i] && (addr_q[i] == rd_addr_hi);
      corr_match[i]  = valid_q[i] && (addr_q[i] == corr_addr);
      wr_lo_match[i] = valid_q[i] && (addr_q[i] == wr_addr);
      wr_hi_match[i] = valid_q[i] && (addr_q[i] == wr_addr_nxt);
      if (lo_match[i])   lo_idx   = IdxW'(i);
      if (hi_match[i])   hi_idx   = IdxW'(i);
      if (corr_match[i]) corr_idx = IdxW'(i);
      if (!valid_q[i])   free_idx = IdxW'(i);
      if (age_q[i] == IdxW'(NUM_RED - 1)) lru_idx = IdxW'(i);
    end
  end

  always_comb begin
    valid_d   = valid_q;
    addr_d    = addr_q;
    data_d    = data_q;
    age_d     = age_q;
    hit_lo_d  = rd_en ? lo_match : '0;
    hit_hi_d  = rd_en ? hi_match : '0;
    evict_d   = 1'b0;
    drop_d    = 1'b0;
    touch_en  = 1'b0;
    touch_idx = '0;
    alloc_idx = any_free ? free_idx : lru_idx;

    if (corr_en) begin
      if (|corr_match) begin
        data_d[corr_idx] = corr_data;
        touch_en         = 1'b1;
        touch_idx        = corr_idx;
      end else if (lock) begin
        drop_d = 1'b1;
      end else begin
        valid_d[alloc_idx] = 1'b1;
        addr_d[alloc_idx]  = corr_addr;
        data_d[alloc_idx]  = corr_data;
        touch_en           = 1'b1;
        touch_idx          = alloc_idx;
        evict_d            = ~any_free;
      end
    end else begin
      if (wr_en) begin
        for (int i = 0; i < NUM_RED; i++) begin
          if (wr_lo_match[i])          data_d[i] = wr_data[DATA_W-1:0];
          if (wr_dw && wr_hi_match[i]) data_d[i] = wr_data[2*DATA_W-1:DATA_W];
        end
      end
      if (rd_en && |lo_match) begin
        touch_en  = 1'b1;
        touch_idx = lo_idx;
      end else if (rd_en && |hi_match) begin
        touch_en  = 1'b1;
        touch_idx = hi_idx;
      end
    end

    // Entries younger than the touched one age by one; the touched one becomes MRU.
    if (touch_en) begin
      for (int i = 0; i < NUM_RED; i++) begin
        if (IdxW'(i) == touch_idx) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[touch_idx]) begin
          age_d[i] = age_q[i] + IdxW'(1);
        end
      end
    end

    if (flush) begin
      valid_d = '0;
      data_d  = data_q;
      addr_d  = addr_q;
      evict_d = 1'b0;
      drop_d  = 1'b0;
      for (int i = 0; i < NUM_RED; i++) begin
        age_d[i] = IdxW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid_q  <= '0;
      hit_lo_q <= '0;
      hit_hi_q <= '0;
      evict_q  <= 1'b0;
      drop_q   <= 1'b0;
      for (int i = 0; i < NUM_RED; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        age_q[i]  <= IdxW'(i);
      end
    end else begin
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      age_q    <= age_d;
      hit_lo_q <= hit_lo_d;
      hit_hi_q <= hit_hi_d;
      evict_q  <= evict_d;
      drop_q   <= drop_d;
    end
  end

  // Forward current entry contents, so a write in the request cycle is visible.
  always_comb begin
    rd_data_lo = ram_dout_lo;
    rd_data_hi = ram_dout_hi;
    occupancy  = '0;
    for (int i = 0; i < NUM_RED; i++) begin
      if (hit_lo_q[i]) rd_data_lo = data_q[i];
      if (hit_hi_q[i]) rd_data_hi = data_q[i];
      occupancy = occupancy + OccW'(valid_q[i]);
    end
  end

  assign full        = (occupancy == OccW'(NUM_RED));
  assign evict_pulse = evict_q;
  assign drop_pulse  = drop_q;

endmodule

// File: tb/tb_el2_ifu_iccm_repair_cam.sv
// Directed bench for el2_ifu_iccm_repair_cam: recency-list reference model checked every
// negedge, plus hand-computed literal expectations along the test sequence.
module tb_el2_ifu_iccm_repair_cam;
  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 39;

  logic            clk = 1'b0;
  logic            rst_l = 1'b0;
  logic            rd_en = 1'b0;
  logic [AW-1:0]   rd_addr_lo = '0;
  logic [AW-1:0]   rd_addr_hi = '0;
  logic [DW-1:0]   ram_dout_lo = '0;
  logic [DW-1:0]   ram_dout_hi = '0;
  logic [DW-1:0]   rd_data_lo, rd_data_hi;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic            wr_dw = 1'b0;
  logic [2*DW-1:0] wr_data = '0;
  logic            corr_en = 1'b0;
  logic [AW-1:0]   corr_addr = '0;
  logic [DW-1:0]   corr_data = '0;
  logic            lock = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      occupancy;
  logic            full, evict_pulse, drop_pulse;

  always #5 clk = ~clk;

  el2_ifu_iccm_repair_cam #(.NUM_RED(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_l(rst_l), .rd_en(rd_en), .rd_addr_lo(rd_addr_lo), .rd_addr_hi(rd_addr_hi),
    .ram_dout_lo(ram_dout_lo), .ram_dout_hi(ram_dout_hi), .rd_data_lo(rd_data_lo),
    .rd_data_hi(rd_data_hi), .wr_en(wr_en), .wr_addr(wr_addr), .wr_dw(wr_dw), .wr_data(wr_data),
    .corr_en(corr_en), .corr_addr(corr_addr), .corr_data(corr_data), .lock(lock), .flush(flush),
    .occupancy(occupancy), .full(full), .evict_pulse(evict_pulse), .drop_pulse(drop_pulse)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: entry table plus a recency list (front = most recently used).
  bit            m_valid [N];
  logic [AW-1:0] m_addr  [N];
  logic [DW-1:0] m_data  [N];
  int            rec [$];
  int            pend_lo, pend_hi;
  bit            e_evict, e_drop;

  function automatic int m_find(input logic [AW-1:0] a);
    for (int i = 0; i < N; i++) if (m_valid[i] && m_addr[i] == a) return i;
    return -1;
  endfunction

  function automatic void m_touch(input int k);
    for (int p = 0; p < rec.size(); p++) begin
      if (rec[p] == k) begin
        rec.delete(p);
        break;
      end
    end
    rec.push_front(k);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = '0;
      m_data[i]  = '0;
    end
    rec = {0, 1, 2, 3};
    pend_lo = -1;
    pend_hi = -1;
    e_evict = 1'b0;
    e_drop  = 1'b0;
  endfunction

  initial begin : cmp
    int plo, phi, k, cnt;
    logic [DW-1:0] exp_lo, exp_hi;
    logic [AW-1:0] a1;
    m_reset();
    forever begin
      @(negedge clk);
      assert (!(corr_en && wr_en)) else $error("FAIL excl: corr_en and wr_en both set");
      if (!rst_l) begin
        m_reset();
        chk("rst rd_lo", rd_data_lo, ram_dout_lo);
        chk("rst rd_hi", rd_data_hi, ram_dout_hi);
        chk("rst occ", occupancy, 0);
        chk("rst full", full, 0);
        chk("rst evict", evict_pulse, 0);
        chk("rst drop", drop_pulse, 0);
      end else begin
        exp_lo = (pend_lo >= 0) ? m_data[pend_lo] : ram_dout_lo;
        exp_hi = (pend_hi >= 0) ? m_data[pend_hi] : ram_dout_hi;
        cnt = m_count();
        chk("model rd_lo", rd_data_lo, exp_lo);
        chk("model rd_hi", rd_data_hi, exp_hi);
        chk("model occ", occupancy, cnt);
        chk("model full", full, (cnt == N));
        chk("model evict", evict_pulse, e_evict);
        chk("model drop", drop_pulse, e_drop);
        // Advance the model by the upcoming clock edge.
        plo = rd_en ? m_find(rd_addr_lo) : -1;
        phi = rd_en ? m_find(rd_addr_hi) : -1;
        e_evict = 1'b0;
        e_drop  = 1'b0;
        if (flush) begin
          for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
          rec = {0, 1, 2, 3};
        end else if (corr_en) begin
          k = m_find(corr_addr);
          if (k >= 0) begin
            m_data[k] = corr_data;
            m_touch(k);
          end else if (lock) begin
            e_drop = 1'b1;
          end else begin
            k = -1;
            for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) k = i;
            if (k < 0) begin
              k = rec[rec.size() - 1];
              e_evict = 1'b1;
            end
            m_valid[k] = 1'b1;
            m_addr[k]  = corr_addr;
            m_data[k]  = corr_data;
            m_touch(k);
          end
        end else begin
          if (wr_en) begin
            k = m_find(wr_addr);
            if (k >= 0) m_data[k] = wr_data[DW-1:0];
            if (wr_dw) begin
              a1 = wr_addr + AW'(1);
              k = m_find(a1);
              if (k >= 0) m_data[k] = wr_data[2*DW-1:DW];
            end
          end
          if (plo >= 0) m_touch(plo);
          else if (phi >= 0) m_touch(phi);
        end
        pend_lo = plo;
        pend_hi = phi;
      end
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
    rd_en = 1'b0; corr_en = 1'b0; wr_en = 1'b0; wr_dw = 1'b0; flush = 1'b0;
    ram_dout_lo = DW'({$urandom, $urandom});
    ram_dout_hi = DW'({$urandom, $urandom});
  endtask

  task automatic settle();
    nc();
    #2;
  endtask

  task automatic corr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    nc(); corr_en = 1'b1; corr_addr = a; corr_data = d;
  endtask

  task automatic rd(input logic [AW-1:0] lo, input logic [AW-1:0] hi);
    nc(); rd_en = 1'b1; rd_addr_lo = lo; rd_addr_hi = hi;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic dw, input logic [2*DW-1:0] d);
    nc(); wr_en = 1'b1; wr_addr = a; wr_dw = dw; wr_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [AW-1:0] ra [4];
    logic [DW-1:0] rdv [4];
    ram_dout_lo = DW'({$urandom, $urandom});
    ram_dout_hi = DW'({$urandom, $urandom});
    repeat (2) @(negedge clk);
    chk("reset occupancy", occupancy, 0);
    chk("reset full", full, 0);
    chk("reset rd_lo passthru", rd_data_lo, ram_dout_lo);
    @(posedge clk);
    #1 rst_l = 1'b1;

    // Fill 0x10..0x40 with data 1..4
    for (int i = 0; i < 4; i++) begin
      corr(AW'(16 * (i + 1)), DW'(i + 1));
      settle();
      chk("fill occupancy", occupancy, i + 1);
      chk("fill full", full, (i == 3));
    end
    rd(14'h20, 14'h21);
    settle();
    chk("fill rd lo 0x20", rd_data_lo, 39'h2);
    chk("fill rd hi 0x21 ram", rd_data_hi, ram_dout_hi);

    // Touch 0x30, 0x40, 0x10 so 0x20 becomes LRU
    ra  = '{14'h30, 14'h40, 14'h10, 14'h10};
    rdv = '{39'h3, 39'h4, 39'h1, 39'h1};
    for (int i = 0; i < 3; i++) begin
      rd(ra[i], ra[i] + AW'(1));
      settle();
      chk("touch rd lo", rd_data_lo, rdv[i]);
    end
    corr(14'h50, 39'h5);
    settle();
    chk("evict pulse", evict_pulse, 1);
    chk("evict occupancy", occupancy, 4);
    settle();
    chk("evict pulse single", evict_pulse, 0);
    rd(14'h20, 14'h21);
    settle();
    chk("evicted 0x20 ram", rd_data_lo, ram_dout_lo);
    rd(14'h10, 14'h11);
    settle();
    chk("kept 0x10", rd_data_lo, 39'h1);

    // Re-correction of a resident address
    corr(14'h30, 39'h7F);
    settle();
    chk("recorr no evict", evict_pulse, 0);
    chk("recorr occupancy", occupancy, 4);
    rd(14'h30, 14'h31);
    settle();
    chk("recorr rd 0x30", rd_data_lo, 39'h7F);

    // Write update: make 0x40 MRU, then 0x41 evicts 0x50
    rd(14'h40, 14'h41);
    corr(14'h41, 39'h41);
    settle();
    chk("alloc 0x41 evict", evict_pulse, 1);
    wr(14'h40, 1'b1, {39'hB, 39'hA});
    rd(14'h40, 14'h41);
    settle();
    chk("dw wr lo", rd_data_lo, 39'hA);
    chk("dw wr hi", rd_data_hi, 39'hB);
    wr(14'h41, 1'b0, {39'h0, 39'hC});
    rd(14'h40, 14'h41);
    settle();
    chk("w wr lo unchanged", rd_data_lo, 39'hA);
    chk("w wr hi", rd_data_hi, 39'hC);

    // Lock and flush
    nc();
    lock = 1'b1;
    corr(14'h60, 39'h66);
    settle();
    chk("lock drop", drop_pulse, 1);
    chk("lock occupancy", occupancy, 4);
    rd(14'h60, 14'h61);
    settle();
    chk("lock 0x60 ram", rd_data_lo, ram_dout_lo);
    corr(14'h40, 39'h44);
    settle();
    chk("lock update no drop", drop_pulse, 0);
    rd(14'h40, 14'h41);
    settle();
    chk("lock update 0x40", rd_data_lo, 39'h44);
    nc();
    flush = 1'b1;
    settle();
    chk("flush occupancy", occupancy, 0);
    chk("flush full", full, 0);
    rd(14'h40, 14'h41);
    settle();
    chk("flush rd lo ram", rd_data_lo, ram_dout_lo);
    chk("flush rd hi ram", rd_data_hi, ram_dout_hi);
    lock = 1'b0;

    // Address wrap
    corr(14'h3FFF, 39'h3FF);
    corr(14'h0000, 39'h100);
    rd(14'h3FFF, 14'h0000);
    settle();
    chk("wrap lo", rd_data_lo, 39'h3FF);
    chk("wrap hi", rd_data_hi, 39'h100);
    wr(14'h3FFF, 1'b1, {39'h222, 39'h111});
    rd(14'h3FFF, 14'h0000);
    settle();
    chk("wrap dw lo", rd_data_lo, 39'h111);
    chk("wrap dw hi", rd_data_hi, 39'h222);

    // Async reset during the data cycle of a hit
    rd(14'h3FFF, 14'h0000);
    nc();
    #1 rst_l = 1'b0;
    #1;
    chk("arst rd lo ram", rd_data_lo, ram_dout_lo);
    chk("arst rd hi ram", rd_data_hi, ram_dout_hi);
    chk("arst occupancy", occupancy, 0);
    nc();
    rst_l = 1'b1;
    rd(14'h3FFF, 14'h0000);
    settle();
    chk("post arst miss", rd_data_lo, ram_dout_lo);
    settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
